oh_7seg_scan: RTL
=================

Name: oh_7seg_scan

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. Holds N BCD digits in a double-buffered register file and sequences them one at a time through a single oh_7seg_decode instance. It drives the shared segment bus and one active-low digit enable per digit, with a blanking gap between digits to prevent ghosting. Sits between a register/CSR block that supplies digit values and the board display pins.

Parameters:
N, 4, number of digits (2..8)
DIVW, 16, width of the per-digit on-time divisor input
BLANK, 2, blanking cycles between digits (>=1), all enables off

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
div  in  DIVW  digit on-time minus 1, in clk cycles; sampled at start of each digit slot
load  in  1  1-cycle strobe: capture din/dp_in into pending buffer
din  in  4*N  BCD digits, digit i = din[4i+3:4i], digit 0 = rightmost
dp_in  in  N  decimal point per digit, 1 = lit
lz_en  in  1  leading-zero suppression enable
seg  out  7  {a,b,c,d,e,f,g}, 1 = off
dp  out  1  decimal point, 1 = off
an  out  N  digit enables, 0 = digit on
frame  out  1  1-cycle pulse at frame boundary (pending->active transfer point)
pending  out  1  pending buffer holds data not yet displayed

Behaviour:
- Reset (sync, active-high): state BLANK, idx=0, cnt=0, active digits all 4'hF (decoder blank), active dp all 0, pending=0, seg=7'h7F, dp=1, an=all 1s, frame=0. Reset mid-frame aborts the slot; display is dark the next cycle.
- FSM states: DRIVE, BLANK.
  - DRIVE: an[idx]=0, other bits 1. seg/dp = decoded active digit idx. Lasts div_q+1 cycles, where div_q = div sampled on BLANK->DRIVE. Then go to BLANK, cnt=0.
  - BLANK: an all 1s, seg=7'h7F, dp=1. Lasts BLANK cycles. On exit idx advances, wrapping N-1 -> 0. Then go to DRIVE.
- div=0 gives a 1-cycle DRIVE. Slot length = div_q+1+BLANK. Frame length = N slots.
- All outputs are registered. seg, dp and an change on the same clock edge; the decode is combinational into the output flops.
- Double-buffering:
  - load writes din/dp_in into the pending buffer and sets pending=1.
  - load while pending=1 overwrites the buffer (last write wins).
  - On the last BLANK cycle with idx=N-1: frame=1; if pending, copy pending->active and clear pending.
  - load on that same cycle: the new data lands in the pending buffer, pending stays 1, and the older pending data is transferred.
- Leading-zero suppression (lz_en=1): digit i (i>=1) is blanked (seg=7'h7F) when it and every higher digit equal 0. Digit 0 is always shown. dp follows dp_in regardless. lz_en is evaluated live against the active buffer.
- Non-BCD digit values (A-F) display blank (decoder default); no error flag.

Decomposition:
- Shared package: FSM state encoding (DRIVE, BLANK), SEG_OFF = 7'h7F constant.
- Sub-module: oh_7seg_decode, one instance on the muxed active digit.
- Leading-zero mask generation is a small function in the package.

Test Plan (N=4, BLANK=2):
- Reset, then div=3, no load -> an cycles 1110,1111x2,1101,... every 6 cycles; seg=7'h7F throughout; frame pulses every 24 cycles.
- load din=16'h1234, dp_in=4'b0100, div=3 -> after the next frame pulse: an=1110 with seg=7'b1001100 ("4"); an=1011 with seg=7'b0010010 and dp=0; DRIVE lasts 4 cycles.
- lz_en=1, load 16'h0070 -> digits 3 and 2 blank, digit 1 = "7" (7'b0001111), digit 0 = "0" (7'b0000001).
- load 16'h1111, then load 16'h2222 before the frame boundary -> only 2222 is ever displayed; pending drops on the frame pulse.
- load asserted exactly on the frame cycle -> the old pending data is displayed; pending stays 1; the new data appears one frame later.
- Assert reset mid-DRIVE of digit 2 -> next cycle an=1111, seg=7'h7F, pending=0; after reset the scan restarts at digit 0 showing blank.

Source files
------------

// File: rtl/oh_7seg_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// FSM encoding, the blank segment pattern and the leading-zero mask helper.
package oh_7seg_scan_pkg;

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit i set when digit i (i>=1) and every higher populated digit are zero.
  function automatic logic [7:0] lz_mask(input logic [31:0] digits, input int unsigned n);
    logic        all_zero;
    int unsigned i;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      i = 7 - k;
      if (i < n) begin
        all_zero = all_zero && (digits[4*i +: 4] == 4'h0);
        if (i != 0 && all_zero) lz_mask[i] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/oh_7seg_scan_decode.sv
// BCD to common-anode 7-segment decoder, {a,b,c,d,e,f,g}, 1 = segment off.
module oh_7seg_decode
  import oh_7seg_scan_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_bcd)
      4'd0: o_seg = 7'b0000001;
      4'd1: o_seg = 7'b1001111;
      4'd2: o_seg = 7'b0010010;
      4'd3: o_seg = 7'b0000110;
      4'd4: o_seg = 7'b1001100;
      4'd5: o_seg = 7'b0100100;
      4'd6: o_seg = 7'b0100000;
      4'd7: o_seg = 7'b0001111;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0000100;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/oh_7seg_scan.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display
// with double-buffered digit storage, blanking gaps and leading-zero suppression.
module oh_7seg_scan
  import oh_7seg_scan_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DIVW  = 16,
  parameter int unsigned BLANK = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DIVW-1:0] div,
  input  logic            load,
  input  logic [4*N-1:0]  din,
  input  logic [N-1:0]    dp_in,
  input  logic            lz_en,
  output logic [6:0]      seg,
  output logic            dp,
  output logic [N-1:0]    an,
  output logic            frame,
  output logic            pending
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned BW = $clog2(BLANK + 1);
  localparam int unsigned CW = (DIVW > BW) ? DIVW : BW;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [DIVW-1:0] r_div_q, w_div_q_nxt;
  logic            r_hold, w_hold_nxt;
  logic            w_frame_now, w_frame_nxt, w_xfer;

  logic [4*N-1:0]  r_act_dig, r_pend_dig, w_act_dig_nxt;
  logic [N-1:0]    r_act_dp, r_pend_dp, w_act_dp_nxt;
  logic            r_pending;

  logic [6:0]      r_seg, w_seg_dec;
  logic            r_dp;
  logic [N-1:0]    r_an;
  logic            r_frame;
  logic [7:0]      w_lz;
  logic [3:0]      w_bcd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BLANK;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_div_q <= '0;
      r_hold  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div_q <= w_div_q_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // r_hold keeps idx at 0 through the first blank after reset so the scan starts at digit 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_div_q_nxt = r_div_q;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
          w_div_q_nxt = div;
          w_hold_nxt  = 1'b0;
          if (!r_hold) w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end
      end
      ST_DRIVE: begin
        if (r_cnt == CW'(r_div_q)) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
        end
      end
    endcase
    w_frame_now = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST) && (r_idx == IDX_LAST) && !r_hold;
    w_frame_nxt = (w_state_nxt == ST_BLANK) && (w_cnt_nxt == BLANK_LAST) &&
                  (w_idx_nxt == IDX_LAST) && !w_hold_nxt;
  end

  assign w_xfer        = w_frame_now && r_pending;
  assign w_act_dig_nxt = w_xfer ? r_pend_dig : r_act_dig;
  assign w_act_dp_nxt  = w_xfer ? r_pend_dp  : r_act_dp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_act_dig  <= '1;
      r_act_dp   <= '0;
      r_pend_dig <= '1;
      r_pend_dp  <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_act_dig <= w_act_dig_nxt;
      r_act_dp  <= w_act_dp_nxt;
      if (load) begin
        r_pend_dig <= din;
        r_pend_dp  <= dp_in;
        r_pending  <= 1'b1;
      end else if (w_xfer) begin
        r_pending  <= 1'b0;
      end
    end
  end

  // Output flops are loaded from next-cycle state and buffer so the pins track the FSM exactly.
  assign w_lz  = lz_mask(32'(w_act_dig_nxt), N);
  assign w_bcd = w_act_dig_nxt[4*w_idx_nxt +: 4];

  oh_7seg_decode u_decode (
    .i_bcd (w_bcd),
    .o_seg (w_seg_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
      r_an    <= '1;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_frame_nxt;
      if (w_state_nxt == ST_DRIVE) begin
        r_an  <= ~(N'(1) << w_idx_nxt);
        r_seg <= (lz_en && w_lz[w_idx_nxt]) ? SEG_OFF : w_seg_dec;
        r_dp  <= ~w_act_dp_nxt[w_idx_nxt];
      end else begin
        r_an  <= '1;
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end
    end
  end

  assign seg     = r_seg;
  assign dp      = r_dp;
  assign an      = r_an;
  assign frame   = r_frame;
  assign pending = r_pending;

endmodule
